// File: rtl/frogger_pkg.sv
// Shared constants for the frogger game-flow controller:
// state encoding, bitmap tile codes and default coordinate width.
package frogger_pkg;

  localparam int COORD_W_DFLT = 6;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLAYING   = 3'd1;
  localparam logic [2:0] ST_DYING     = 3'd2;
  localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic [2:0] TILE_WALL  = 3'd0;
  localparam logic [2:0] TILE_ROAD  = 3'd1;
  localparam logic [2:0] TILE_WATER = 3'd2;
  localparam logic [2:0] TILE_SAFE  = 3'd3;
  localparam logic [2:0] TILE_GOAL  = 3'd4;

endpackage

// File: rtl/frogger_game_fsm_if.sv
// Frog/car position bus shared between the game FSM
// and the collision checker.
interface frogger_game_fsm_if
  import frogger_pkg::*;
#(
  parameter int NUM_CARS = 10,
  parameter int COORD_W  = COORD_W_DFLT
);

  logic [COORD_W-1:0]          frog_x;
  logic [COORD_W-1:0]          frog_y;
  logic [NUM_CARS*COORD_W-1:0] car_x;
  logic [NUM_CARS*COORD_W-1:0] car_y;

  modport master (
    output frog_x, frog_y, car_x, car_y
  );

  modport slave (
    input frog_x, frog_y, car_x, car_y
  );

endinterface

// File: rtl/frogger_collide.sv
// Combinational frog-vs-cars overlap: OR of per-car
// full-width X/Y equality.
module frogger_collide #(
  parameter int NUM_CARS = 10,
  parameter int COORD_W  = 6
) (
  frogger_game_fsm_if.slave bus_i,
  output logic              o_Car_Hit
);

  always_comb begin
    o_Car_Hit = 1'b0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (bus_i.car_x[k*COORD_W +: COORD_W] == bus_i.frog_x &&
          bus_i.car_y[k*COORD_W +: COORD_W] == bus_i.frog_y)
        o_Car_Hit = 1'b1;
    end
  end

endmodule

// File: rtl/frogger_game_fsm.sv
// Frame-paced round controller: start, play, death, level-up,
// game over; owns lives, level, score, goals and life timer.
module frogger_game_fsm #(
  parameter int          NUM_CARS        = 10,
  parameter int          COORD_W         = frogger_pkg::COORD_W_DFLT,
  parameter int          NUM_LIVES       = 3,
  parameter int          LIFE_FRAMES     = 1800,
  parameter int          DEATH_FRAMES    = 60,
  parameter int          LEVELUP_FRAMES  = 90,
  parameter int          GOALS_PER_LEVEL = 5,
  parameter int          MAX_LEVEL       = 7,
  parameter int          SCORE_MAX       = 99,
  parameter logic [2:0]  TILE_WATER      = frogger_pkg::TILE_WATER,
  parameter logic [2:0]  TILE_GOAL       = frogger_pkg::TILE_GOAL
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  input  logic                        i_Frame_Tick,
  input  logic                        i_Game_Start,
  input  logic [COORD_W-1:0]          i_Frog_X,
  input  logic [COORD_W-1:0]          i_Frog_Y,
  input  logic [2:0]                  i_Tile,
  input  logic [NUM_CARS*COORD_W-1:0] i_Car_X,
  input  logic [NUM_CARS*COORD_W-1:0] i_Car_Y,
  output logic [2:0]                  o_State,
  output logic                        o_Frog_Reset,
  output logic                        o_Hit,
  output logic [2:0]                  o_Lives,
  output logic [2:0]                  o_Level,
  output logic [6:0]                  o_Score,
  output logic [10:0]                 o_Timer
);

  import frogger_pkg::*;

  localparam int GW   = $clog2(GOALS_PER_LEVEL + 1);
  localparam int FMAX = (DEATH_FRAMES > LEVELUP_FRAMES) ?
                        DEATH_FRAMES : LEVELUP_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  localparam logic [10:0]   TMR_INIT = 11'(LIFE_FRAMES);
  localparam logic [2:0]    LIV_INIT = 3'(NUM_LIVES);
  localparam logic [FW-1:0] DIE_LAST = FW'(DEATH_FRAMES - 1);
  localparam logic [FW-1:0] LVL_LAST = FW'(LEVELUP_FRAMES - 1);

  frogger_game_fsm_if #(
    .NUM_CARS (NUM_CARS),
    .COORD_W  (COORD_W)
  ) pos_if ();

  assign pos_if.frog_x = i_Frog_X;
  assign pos_if.frog_y = i_Frog_Y;
  assign pos_if.car_x  = i_Car_X;
  assign pos_if.car_y  = i_Car_Y;

  logic car_hit;

  frogger_collide #(
    .NUM_CARS (NUM_CARS),
    .COORD_W  (COORD_W)
  ) u_collide (
    .bus_i     (pos_if),
    .o_Car_Hit (car_hit)
  );

  logic [2:0]    state_q, state_d;
  logic [2:0]    lives_q, lives_d;
  logic [2:0]    level_q, level_d;
  logic [6:0]    score_q, score_d;
  logic [GW-1:0] goals_q, goals_d;
  logic [10:0]   timer_q, timer_d;
  logic [FW-1:0] frm_q,   frm_d;
  logic          start_q;
  logic          frst_q,  frst_d;
  logic          hit_q,   hit_d;

  logic start_edge;
  logic fatal;
  logic goal;

  assign start_edge = i_Game_Start & ~start_q;
  assign fatal = car_hit | (i_Tile == TILE_WATER) |
                 (i_Frame_Tick & (timer_q == 11'd1));
  assign goal  = (i_Frog_Y == '0) & (i_Tile == TILE_GOAL);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    score_d = score_q;
    goals_d = goals_q;
    timer_d = timer_q;
    frm_d   = frm_q;
    frst_d  = 1'b0;
    hit_d   = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE),
      (state_q == ST_GAME_OVER): begin
        if (start_edge) begin
          state_d = ST_PLAYING;
          lives_d = LIV_INIT;
          level_d = '0;
          score_d = '0;
          goals_d = '0;
          timer_d = TMR_INIT;
          frm_d   = '0;
          frst_d  = 1'b1;
        end
      end
      (state_q == ST_PLAYING): begin
        if (i_Frame_Tick && timer_q != '0)
          timer_d = timer_q - 11'd1;
        // fatal takes priority over a simultaneous goal
        if (fatal) begin
          state_d = ST_DYING;
          hit_d   = 1'b1;
          lives_d = (lives_q == '0) ? '0 : lives_q - 3'd1;
          frm_d   = '0;
        end else if (goal) begin
          score_d = (score_q == 7'(SCORE_MAX)) ?
                    score_q : score_q + 7'd1;
          timer_d = TMR_INIT;
          frst_d  = 1'b1;
          if (goals_q + GW'(1) == GW'(GOALS_PER_LEVEL)) begin
            state_d = ST_LEVEL_UP;
            goals_d = '0;
            frm_d   = '0;
          end else begin
            goals_d = goals_q + GW'(1);
          end
        end
      end
      (state_q == ST_DYING): begin
        if (i_Frame_Tick) begin
          if (frm_q == DIE_LAST) begin
            frm_d = '0;
            if (lives_q == '0) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d = ST_PLAYING;
              timer_d = TMR_INIT;
              frst_d  = 1'b1;
            end
          end else begin
            frm_d = frm_q + FW'(1);
          end
        end
      end
      (state_q == ST_LEVEL_UP): begin
        if (i_Frame_Tick) begin
          if (frm_q == LVL_LAST) begin
            frm_d   = '0;
            state_d = ST_PLAYING;
            level_d = (level_q == 3'(MAX_LEVEL)) ?
                      level_q : level_q + 3'd1;
            timer_d = TMR_INIT;
            frst_d  = 1'b1;
          end else begin
            frm_d = frm_q + FW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        frm_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      lives_q <= LIV_INIT;
      level_q <= '0;
      score_q <= '0;
      goals_q <= '0;
      timer_q <= TMR_INIT;
      frm_q   <= '0;
      start_q <= 1'b0;
      frst_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      score_q <= score_d;
      goals_q <= goals_d;
      timer_q <= timer_d;
      frm_q   <= frm_d;
      start_q <= i_Game_Start;
      frst_q  <= frst_d;
      hit_q   <= hit_d;
    end
  end

  assign o_State      = state_q;
  assign o_Frog_Reset = frst_q;
  assign o_Hit        = hit_q;
  assign o_Lives      = lives_q;
  assign o_Level      = level_q;
  assign o_Score      = score_q;
  assign o_Timer      = timer_q;

endmodule

// File: doc/frogger_game_fsm.md
Name: frogger_game_fsm

Overview:
Parametrised game-flow controller, successor to the fixed top-level collision and score logic. It owns the complete round sequence:
- start, play, death animation, level-up pause, game over;
- collision against N cars plus hazard tiles;
- per-life countdown timer, lives, goals, level and saturating score.

It sits between frogger_ctrl (frog position), multi_car_ctrl (car positions, speed by level) and score_control (7-seg), and is frame-paced by a VSync-derived tick.

Parameters:
NUM_CARS, 10, cars checked for collision
COORD_W, 6, width of each X/Y tile coordinate
NUM_LIVES, 3, lives loaded at game start (1..7)
LIFE_FRAMES, 1800, frames per life before timeout (30 s at 60 Hz)
DEATH_FRAMES, 60, frames spent in DYING
LEVELUP_FRAMES, 90, frames spent in LEVEL_UP
GOALS_PER_LEVEL, 5, goals needed to advance a level
MAX_LEVEL, 7, level saturation value
SCORE_MAX, 99, score saturation value (two 7-seg digits)
TILE_WATER, 2, bitmap code that kills the frog
TILE_GOAL, 4, bitmap code for lily pad (goal)

Ports:
i_Clk  in  1  system clock (25 MHz pixel clock)
i_Rst_L  in  1  asynchronous active-low reset
i_Frame_Tick  in  1  one-cycle pulse per frame
i_Game_Start  in  1  start button (debounced level)
i_Frog_X  in  COORD_W  frog tile column
i_Frog_Y  in  COORD_W  frog tile row
i_Tile  in  3  bitmap code under the frog
i_Car_X  in  NUM_CARS*COORD_W  flattened car columns (car k at [k*COORD_W +: COORD_W])
i_Car_Y  in  NUM_CARS*COORD_W  flattened car rows
o_State  out  3  IDLE=0, PLAYING=1, DYING=2, LEVEL_UP=3, GAME_OVER=4
o_Frog_Reset  out  1  one-cycle pulse: return frog to start tile
o_Hit  out  1  one-cycle pulse on a fatal event
o_Lives  out  3  remaining lives
o_Level  out  3  current level (drives car speed)
o_Score  out  7  saturating score
o_Timer  out  11  frames left in the current life

Behaviour:
Reset (i_Rst_L low, asynchronous):
- state IDLE, lives NUM_LIVES, level 0, score 0, goals 0, timer LIFE_FRAMES, all pulses 0.
- Release of reset is synchronous to i_Clk.

Start detection:
- i_Game_Start is rising-edge detected internally via one register; a held level never retriggers.

Fatal event (evaluated only in PLAYING):
- any car k with i_Car_X[k]==i_Frog_X and i_Car_Y[k]==i_Frog_Y; or
- i_Tile==TILE_WATER; or
- i_Frame_Tick while timer==1.

Goal (evaluated only in PLAYING): i_Frog_Y==0 and i_Tile==TILE_GOAL.

Latency: an event combinationally present at edge N produces the state change, counter updates and pulses registered at edge N+1.

IDLE:
- start edge -> PLAYING; lives=NUM_LIVES, level=0, score=0, goals=0, timer=LIFE_FRAMES; o_Frog_Reset pulses.

PLAYING:
- Timer decrements by 1 on each i_Frame_Tick.
- Fatal event -> DYING; o_Hit pulses; lives decrement (floor 0); frame counter cleared.
- Goal -> score+1 (saturate at SCORE_MAX), goals+1, timer reloaded, o_Frog_Reset pulses.
- If goals+1==GOALS_PER_LEVEL -> LEVEL_UP with goals cleared; otherwise stay in PLAYING.
- Fatal event and goal in the same cycle: fatal wins, no score.

DYING:
- Count DEATH_FRAMES ticks.
- Then, if lives==0 -> GAME_OVER.
- Otherwise -> PLAYING; timer reloaded; o_Frog_Reset pulses.

LEVEL_UP:
- Count LEVELUP_FRAMES ticks.
- Then level+1 (saturate at MAX_LEVEL), timer reloaded, o_Frog_Reset pulses -> PLAYING.

GAME_OVER:
- All counters hold.
- Start edge behaves exactly as the IDLE start (new game, full reload).

Other rules:
- Ticks outside PLAYING, DYING and LEVEL_UP are ignored.
- Frame counters are cleared on every state entry.
- A start edge in PLAYING, DYING or LEVEL_UP is ignored.
- Reset mid-operation returns to the reset values immediately; no pulse is emitted.
- Collision compare is a NUM_CARS-wide OR reduction; car coordinates are compared at full COORD_W width.

Decomposition:
- Shared package frogger_pkg holds:
  - state encoding constants (ST_IDLE..ST_GAME_OVER);
  - tile codes (TILE_WALL=0, ROAD=1, WATER=2, SAFE=3, GOAL=4);
  - COORD_W default.
- One sub-module, frogger_collide: purely combinational OR-reduction over NUM_CARS, outputs o_Car_Hit.
- The frame-counter and timer logic stay inline.

Test Plan:
1. Reset low mid-PLAYING with lives=1 -> next sampled o_State=0, o_Lives=3, o_Score=0, o_Timer=1800, no o_Frog_Reset pulse.
2. Start edge with frog (9,14) on a road tile and no car overlap -> PLAYING and o_Frog_Reset pulses one cycle. Then put car 7 at (9,14) -> o_Hit pulses at N+1, o_Lives=2, o_State=2. After 60 ticks -> o_State=1 with o_Frog_Reset pulse.
3. With LIFE_FRAMES=5, apply 5 ticks with no events -> o_Hit on the 5th tick, o_Lives decrements, o_Timer reloaded on return to PLAYING.
4. Frog (3,0) with tile 4, repeated 5 times with frog reset between -> o_Score 1..5. The 5th goal gives o_State=3; after 90 ticks o_Level=1, o_State=1.
5. Same cycle: car on the frog and tile 4 at row 0 -> DYING, o_Score unchanged. Score preloaded to 99 plus a goal -> o_Score stays 99.
6. Lose all 3 lives -> o_State=4. Holding i_Game_Start high gives no restart; release and re-press -> PLAYING, o_Lives=3, o_Level=0, o_Score=0.
